// File: rtl/router_nport.sv
// router_nport -- N-port bit-serial packet router.
// Each input shifts in an ADDR_W-bit destination address (LSB first). It then requests
// that output and, once granted, forwards its payload to it with one cycle of latency.
// Each output has an arbiter. The winner keeps ownership of the output until its frame drops.
//
// Build option: define ROUTER_RR_EN to select round-robin arbitration per output.
// When it is undefined, arbitration is fixed priority (the lowest input index wins) and
// no round-robin pointers exist.
//
// Input FSM states:
//   state  | meaning
//   S_IDLE | waiting for frame; the first frame cycle carries address bit 0
//   S_ADDR | shifting in the remaining address bits
//   S_REQ  | address valid, requesting output r_addr
//   S_FWD  | owns output r_addr, copying frame/valid/data through
//   S_DROP | address out of range, discarding until the frame drops
module router_nport #(
  parameter int N_PORTS = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_PORTS-1:0] i_frame,
  input  logic [N_PORTS-1:0] i_valid,
  input  logic [N_PORTS-1:0] i_data,
  output logic [N_PORTS-1:0] o_grant,
  output logic [N_PORTS-1:0] o_frame,
  output logic [N_PORTS-1:0] o_valid,
  output logic [N_PORTS-1:0] o_data
);

  localparam int ADDR_W = (N_PORTS > 2) ? $clog2(N_PORTS) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_REQ  = 3'd2,
    S_FWD  = 3'd3,
    S_DROP = 3'd4
  } state_t;

  // per-input state
  state_t            r_state     [N_PORTS];
  state_t            w_state_nxt [N_PORTS];
  logic [ADDR_W-1:0] r_addr      [N_PORTS];
  logic [ADDR_W-1:0] r_bitcnt    [N_PORTS];
  logic [ADDR_W-1:0] w_addr_new  [N_PORTS];
  logic [N_PORTS-1:0] w_addr_last;
  logic [N_PORTS-1:0] w_addr_ok;
  logic [N_PORTS-1:0] w_won;
  logic [N_PORTS-1:0] r_grant;

  // per-output arbitration and ownership; w_req[j][i] means input i requests output j
  logic [N_PORTS-1:0] w_req       [N_PORTS];
  logic [N_PORTS-1:0] w_win_vld;
  logic [ADDR_W-1:0]  w_win_idx   [N_PORTS];
  logic [N_PORTS-1:0] r_owned;
  logic [ADDR_W-1:0]  r_owner     [N_PORTS];
  int                 w_base;
`ifdef ROUTER_RR_EN
  logic [ADDR_W-1:0]  r_ptr       [N_PORTS];
`endif

  // registered output lanes
  logic [N_PORTS-1:0] r_frame;
  logic [N_PORTS-1:0] r_valid;
  logic [N_PORTS-1:0] r_data;

  function automatic int cand(input int base, input int off);
    return (base + off) % N_PORTS;
  endfunction

  // Insert this cycle's data bit into the address and flag the last address bit.
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      w_addr_new[i]  = '0;
      w_addr_last[i] = 1'b0;
      if (r_state[i] == S_IDLE) begin
        w_addr_new[i][0] = i_data[i];
        w_addr_last[i]   = (ADDR_W == 1);
      end else begin
        w_addr_new[i]              = r_addr[i];
        w_addr_new[i][r_bitcnt[i]] = i_data[i];
        w_addr_last[i]             = (r_bitcnt[i] == ADDR_W'(ADDR_W - 1));
      end
      w_addr_ok[i] = (int'(w_addr_new[i]) < N_PORTS);
    end
  end

  // Request matrix: an input requests only while in REQ with its frame still high.
  always_comb begin
    for (int j = 0; j < N_PORTS; j++) begin
      w_req[j] = '0;
      for (int i = 0; i < N_PORTS; i++) begin
        w_req[j][i] = (r_state[i] == S_REQ) && i_frame[i] && (r_addr[i] == ADDR_W'(j));
      end
    end
  end

  // Per-output arbiter; an output owned before this edge takes no new winner.
  always_comb begin
    w_base = 0;
    for (int j = 0; j < N_PORTS; j++) begin
      w_win_vld[j] = 1'b0;
      w_win_idx[j] = '0;
`ifdef ROUTER_RR_EN
      w_base = int'(r_ptr[j]);
`else
      w_base = 0;
`endif
      if (!r_owned[j]) begin
        for (int off = 0; off < N_PORTS; off++) begin
          if (!w_win_vld[j] && w_req[j][cand(w_base, off)]) begin
            w_win_vld[j] = 1'b1;
            w_win_idx[j] = ADDR_W'(cand(w_base, off));
          end
        end
      end
    end
  end

  // Fold the per-output winners back onto the inputs.
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      w_won[i] = 1'b0;
      for (int j = 0; j < N_PORTS; j++) begin
        if (w_win_vld[j] && (w_win_idx[j] == ADDR_W'(i))) begin
          w_won[i] = 1'b1;
        end
      end
    end
  end

  // Input FSM next-state logic.
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      w_state_nxt[i] = r_state[i];
      case (r_state[i])
        S_IDLE: begin
          if (i_frame[i]) begin
            if (!w_addr_last[i])    w_state_nxt[i] = S_ADDR;
            else if (w_addr_ok[i])  w_state_nxt[i] = S_REQ;
            else                    w_state_nxt[i] = S_DROP;
          end
        end
        S_ADDR: begin
          if (!i_frame[i])          w_state_nxt[i] = S_IDLE;
          else if (w_addr_last[i])  w_state_nxt[i] = w_addr_ok[i] ? S_REQ : S_DROP;
        end
        S_REQ: begin
          if (!i_frame[i])          w_state_nxt[i] = S_IDLE;
          else if (w_won[i])        w_state_nxt[i] = S_FWD;
        end
        S_FWD, S_DROP: begin
          if (!i_frame[i])          w_state_nxt[i] = S_IDLE;
        end
        default:                    w_state_nxt[i] = S_IDLE;
      endcase
    end
  end

  // Input FSM state register.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_PORTS; i++) begin
      if (!reset_n) r_state[i] <= S_IDLE;
      else          r_state[i] <= w_state_nxt[i];
    end
  end

  // Address shift register, saturating bit counter and per-input grant.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_PORTS; i++) begin
      if (!reset_n) begin
        r_addr[i]   <= '0;
        r_bitcnt[i] <= '0;
        r_grant[i]  <= 1'b0;
      end else begin
        if (i_frame[i] && (r_state[i] == S_IDLE)) begin
          r_addr[i]   <= w_addr_new[i];
          r_bitcnt[i] <= (ADDR_W > 1) ? ADDR_W'(1) : '0;
        end else if (i_frame[i] && (r_state[i] == S_ADDR)) begin
          r_addr[i] <= w_addr_new[i];
          if (!w_addr_last[i]) r_bitcnt[i] <= r_bitcnt[i] + 1'b1;
        end
        r_grant[i] <= (w_state_nxt[i] == S_FWD);
      end
    end
  end

  // Output ownership: release when the owner's frame drops, otherwise accept a winner.
  always_ff @(posedge clk) begin
    for (int j = 0; j < N_PORTS; j++) begin
      if (!reset_n) begin
        r_owned[j] <= 1'b0;
        r_owner[j] <= '0;
`ifdef ROUTER_RR_EN
        r_ptr[j]   <= '0;
`endif
      end else if (r_owned[j]) begin
        if (!i_frame[r_owner[j]]) r_owned[j] <= 1'b0;
      end else if (w_win_vld[j]) begin
        r_owned[j] <= 1'b1;
        r_owner[j] <= w_win_idx[j];
`ifdef ROUTER_RR_EN
        r_ptr[j]   <= ADDR_W'((int'(w_win_idx[j]) + 1) % N_PORTS);
`endif
      end
    end
  end

  // Registered payload copy from the owning input; lanes go idle when the frame drops.
  always_ff @(posedge clk) begin
    for (int j = 0; j < N_PORTS; j++) begin
      if (!reset_n) begin
        r_frame[j] <= 1'b0;
        r_valid[j] <= 1'b0;
        r_data[j]  <= 1'b0;
      end else if (r_owned[j] && i_frame[r_owner[j]]) begin
        r_frame[j] <= 1'b1;
        r_valid[j] <= i_valid[r_owner[j]];
        r_data[j]  <= i_data[r_owner[j]];
      end else begin
        r_frame[j] <= 1'b0;
        r_valid[j] <= 1'b0;
        r_data[j]  <= 1'b0;
      end
    end
  end

  assign o_grant = r_grant;
  assign o_frame = r_frame;
  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule
